apb_sram_responder: RTL and testbench
=====================================

APB_SRAM_RESPONDER -- requirements
Module: apb_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'ha000_0000, base of the decoded window.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-003 SHALL have parameter DEFAULT_WAIT, default 8'd4, reset value of the wait-state register.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port in_paddr, input, 32, APB address.
REQ-007 SHALL have port in_psel, input, 1, APB select.
REQ-008 SHALL have port in_penable, input, 1, APB access-phase flag.
REQ-009 SHALL have port in_pprot, input, 3, APB protection; accepted and ignored.
REQ-010 SHALL have port in_pwrite, input, 1, 1 = write.
REQ-011 SHALL have port in_pwdata, input, 32, write data.
REQ-012 SHALL have port in_pstrb, input, 4, byte write strobes.
REQ-013 SHALL have port in_pready, output, 1, transfer completion.
REQ-014 SHALL have port in_prdata, output, 32, read data.
REQ-015 SHALL have port in_pslverr, output, 1, error response.

Function
REQ-016 Address map (offset = in_paddr - BASE_ADDR): 0x0..DEPTH_WORDS*4-1 storage; 0x1_0000 WAIT CSR (bits 7:0 RW, 31:8 read 0); 0x1_0004 COUNT (RO, 32-bit completed-transfer count); all other addresses, including any below BASE_ADDR, SHALL be unmapped.
REQ-017 SHALL implement FSM states IDLE and ACCESS.
REQ-018 IDLE: on in_psel=1 and in_penable=0 (setup), SHALL latch addr, write, wdata and strb, load wait counter from WAIT CSR[7:0], and go to ACCESS.
REQ-019 ACCESS: while in_psel=1, in_penable=1 and counter!=0, counter SHALL decrement by 1 per cycle.
REQ-020 in_pready SHALL be combinational, equal to (state==ACCESS && counter==0 && in_psel && in_penable); it is 0 in every other case.
REQ-021 Latency: with setup in cycle T0 and latched wait W, in_pready SHALL first be 1 in cycle T0+1+W; W=0 gives a zero-wait transfer; W=255 gives the maximum.
REQ-022 On the completing edge (in_pready=1), an OK write SHALL update the storage bytes selected by latched strb, and state SHALL return to IDLE; a setup in the next cycle SHALL be accepted (back-to-back).
REQ-023 Storage read data SHALL be captured at the setup edge; in_prdata SHALL present it (or the CSR value) only while in_pready=1, and 0 otherwise.
REQ-024 in_pslverr SHALL be 1 only with in_pready=1 and only for unmapped addresses or writes to COUNT; such transfers SHALL have no side effect and SHALL use the normal wait latency.
REQ-025 A write to WAIT CSR SHALL update only when strb[0]=1; the new value applies from the next setup, not the current transfer.
REQ-026 A write with strb=4'b0000 SHALL complete OK with no state change.
REQ-027 COUNT SHALL increment by 1 on every completed transfer, OK or error, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 If in_psel drops in ACCESS before completion, the block SHALL return to IDLE with no write and no count increment.

Reset
REQ-029 When reset=0 at a clock edge: state=IDLE, counter=0, WAIT CSR=DEFAULT_WAIT, COUNT=0, latched fields=0; in_pready, in_pslverr and in_prdata are 0 from the next cycle.
REQ-030 Reset during ACCESS SHALL abort the transfer with no write; storage contents SHALL NOT be reset.

Structure
REQ-031 Package apb_resp_pkg SHALL hold the state enum and the CSR offset constants (WAIT_OFS, COUNT_OFS).
REQ-032 Storage SHALL be a sub-module apb_bytemem (DEPTH_WORDS x 32, per-byte write enable, synchronous read).

Verification
REQ-033 Reset, then read 0x1_0000 -> prdata=32'h4, pready on the 5th access cycle, pslverr=0.
REQ-034 Write WAIT=0, then write 0xDEADBEEF to BASE+0x8 with strb=4'b0011, then read it -> pready in the first access cycle; read returns 0xXXXXBEEF (upper bytes unchanged from prior content).
REQ-035 Read BASE+0x2_0000, then write COUNT -> both pslverr=1; the following COUNT read returns 3 (the two error transfers plus the WAIT write); storage unchanged.
REQ-036 WAIT=255 transfer -> pready exactly 256 cycles after setup; deassert psel mid-wait on a write -> no write, COUNT unchanged.
REQ-037 Ten back-to-back writes with no idle cycle, then reset asserted in the middle of an eleventh ACCESS -> the ten locations hold their data, WAIT=4, COUNT=0.

Source files
------------

// File: rtl/apb_resp_pkg.sv
// Shared types and CSR map for the APB SRAM responder.
package apb_resp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RGN_MEM   = 2'd0,
        RGN_WAIT  = 2'd1,
        RGN_COUNT = 2'd2,
        RGN_NONE  = 2'd3
    } region_e;

    localparam logic [31:0] WAIT_OFS  = 32'h0001_0000;
    localparam logic [31:0] COUNT_OFS = 32'h0001_0004;

    // Addresses below the base wrap to huge offsets, so they are rejected explicitly.
    function automatic region_e decode_region(input logic [31:0] paddr,
                                              input logic [31:0] base,
                                              input logic [32:0] mem_bytes);
        logic [31:0] ofs;
        region_e     rgn;
        ofs = paddr - base;
        if (paddr < base) begin
            rgn = RGN_NONE;
        end else if ({1'b0, ofs} < mem_bytes) begin
            rgn = RGN_MEM;
        end else if (ofs == WAIT_OFS) begin
            rgn = RGN_WAIT;
        end else if (ofs == COUNT_OFS) begin
            rgn = RGN_COUNT;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/apb_bytemem.sv
// Word-organised storage with per-byte write enables and a registered read port.
module apb_bytemem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; the read register holds until the next read.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_sram_responder.sv
// APB completer: SRAM window plus WAIT and COUNT CSRs, with programmable wait states.
module apb_sram_responder
    import apb_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'ha000_0000,
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [7:0]  DEFAULT_WAIT = 8'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    wait_q, wait_d;
    logic [31:0]   count_q, count_d;
    logic [AW-1:0] word_q, word_d;
    region_e       region_q, region_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    strb_q, strb_d;

    logic [31:0]   ofs;
    logic          setup;
    logic          err;
    logic          ok_write;
    logic [31:0]   mem_rdata;
    logic [3:0]    mem_we;
    logic          unused_ok;

    assign ofs       = in_paddr - BASE_ADDR;
    assign unused_ok = ^{in_pprot, ofs};

    // Handshake: a setup is psel=1/penable=0 in IDLE; the transfer completes on the
    // edge where psel=1, penable=1 and pready=1; dropping psel in ACCESS abandons it.
    assign setup     = (state_q == ST_IDLE) && in_psel && !in_penable;
    assign in_pready = (state_q == ST_ACCESS) && (cnt_q == 8'd0) && in_psel && in_penable;
    assign err       = (region_q == RGN_NONE) || ((region_q == RGN_COUNT) && write_q);
    assign ok_write  = in_pready && write_q && !err && reset;

    assign in_pslverr = in_pready && err;
    assign mem_we     = (ok_write && (region_q == RGN_MEM)) ? strb_q : 4'b0000;

    always_comb begin
        in_prdata = 32'd0;
        if (in_pready && !err && !write_q) begin
            case (region_q)
                RGN_MEM:   in_prdata = mem_rdata;
                RGN_WAIT:  in_prdata = {24'd0, wait_q};
                RGN_COUNT: in_prdata = count_q;
                default:   in_prdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        count_d  = count_q;
        word_d   = word_q;
        region_d = region_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = wait_q;
                    word_d   = ofs[AW+1:2];
                    region_d = decode_region(in_paddr, BASE_ADDR, MEM_BYTES);
                    write_d  = in_pwrite;
                    wdata_d  = in_pwdata;
                    strb_d   = in_pstrb;
                end
            end
            ST_ACCESS: begin
                if (!in_psel) begin
                    state_d = ST_IDLE;
                end else if (in_pready) begin
                    state_d = ST_IDLE;
                    count_d = count_q + 32'd1;
                    if (ok_write && (region_q == RGN_WAIT) && strb_q[0]) begin
                        wait_d = wdata_q[7:0];
                    end
                end else if (in_penable && (cnt_q != 8'd0)) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            wait_q   <= DEFAULT_WAIT;
            count_q  <= 32'd0;
            word_q   <= '0;
            region_q <= RGN_MEM;
            write_q  <= 1'b0;
            wdata_q  <= 32'd0;
            strb_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
            word_q   <= word_d;
            region_q <= region_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
        end
    end

    apb_bytemem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk_i   (clock),
        .re_i    (setup),
        .raddr_i (ofs[AW+1:2]),
        .rdata_o (mem_rdata),
        .we_i    (mem_we),
        .waddr_i (word_q),
        .wdata_i (wdata_q)
    );

endmodule

// File: tb/tb_apb_sram_responder.sv
// Bench for apb_sram_responder: directed vector table, hand sequences and a random run against a map model.
module tb_apb_sram_responder;

    localparam logic [31:0] BASE  = 32'ha000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] WAITA = BASE + 32'h0001_0000;
    localparam logic [31:0] CNTA  = BASE + 32'h0001_0004;
    localparam int          LAT_BOUND = 300;

    logic        clock;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    int n_cmp;
    int n_err;

    // reference model state
    logic [31:0] mem_m [int unsigned];
    logic [7:0]  wait_m;
    logic [31:0] count_m;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [21];

    apb_sram_responder #(
        .BASE_ADDR    (BASE),
        .DEPTH_WORDS  (DEPTH),
        .DEFAULT_WAIT (8'd4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_paddr   (in_paddr),
        .in_psel    (in_psel),
        .in_penable (in_penable),
        .in_pprot   (in_pprot),
        .in_pwrite  (in_pwrite),
        .in_pwdata  (in_pwdata),
        .in_pstrb   (in_pstrb),
        .in_pready  (in_pready),
        .in_prdata  (in_prdata),
        .in_pslverr (in_pslverr)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        in_psel    = 1'b0;
        in_penable = 1'b0;
        in_pwrite  = 1'b0;
        in_paddr   = 32'd0;
        in_pwdata  = 32'd0;
        in_pstrb   = 4'd0;
        in_pprot   = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        bus_idle();
        repeat (2) @(negedge clock);
        reset   = 1'b1;
        wait_m  = 8'd4;
        count_m = 32'd0;
    endtask

    task automatic check_outputs_idle(input string tag);
        #1;
        check({tag, " pready"},  {31'd0, in_pready},  32'd0);
        check({tag, " pslverr"}, {31'd0, in_pslverr}, 32'd0);
        check({tag, " prdata"},  in_prdata,            32'd0);
    endtask

    // Model of one completed transfer, written from the address map rules.
    task automatic model_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd, output logic err,
                              output int lat);
        logic [31:0] off;
        logic [31:0] w;
        int unsigned idx;
        int          kind; // 0 mem, 1 wait, 2 count, 3 unmapped
        off = addr - BASE;
        lat = int'(wait_m) + 1;
        if (addr < BASE)                kind = 3;
        else if (off < DEPTH * 4)       kind = 0;
        else if (off == 32'h0001_0000)  kind = 1;
        else if (off == 32'h0001_0004)  kind = 2;
        else                            kind = 3;
        err = (kind == 3) || (kind == 2 && wr);
        rd  = 32'd0;
        if (!err) begin
            idx = off / 4;
            if (kind == 0) begin
                w = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
                if (wr) begin
                    for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
                    mem_m[idx] = w;
                end else begin
                    rd = w;
                end
            end else if (kind == 1) begin
                if (wr) begin
                    if (st[0]) wait_m = wd[7:0];
                end else begin
                    rd = {24'd0, wait_m};
                end
            end else begin
                rd = count_m;
            end
        end
        count_m = count_m + 32'd1;
    endtask

    // Driver: setup then access until pready, sampled 1 time unit after each negedge.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, output logic [31:0] rd, output logic err,
                            output int lat);
        @(negedge clock);
        in_psel    = 1'b1;
        in_penable = 1'b0;
        in_paddr   = addr;
        in_pwrite  = wr;
        in_pwdata  = wd;
        in_pstrb   = st;
        in_pprot   = 3'($urandom_range(0, 7));
        @(negedge clock);
        in_penable = 1'b1;
        lat = 1;
        #1;
        while (!in_pready && lat < LAT_BOUND) begin
            @(negedge clock);
            #1;
            lat++;
        end
        rd  = in_prdata;
        err = in_pslverr;
        if (in_pready) begin
            @(posedge clock);
            #1;
            bus_idle();
        end else begin
            lat = LAT_BOUND;
            bus_idle();
            @(negedge clock);
        end
    endtask

    task automatic xfer_vs_model(input string name, input logic [31:0] addr, input logic wr,
                                 input logic [31:0] wd, input logic [3:0] st,
                                 output logic [31:0] rd_out);
        logic [31:0] e_rd, a_rd;
        logic        e_err, a_err;
        int          e_lat, a_lat;
        model_xfer(addr, wr, wd, st, e_rd, e_err, e_lat);
        apb_xfer(addr, wr, wd, st, a_rd, a_err, a_lat);
        check({name, " pslverr"}, {31'd0, a_err}, {31'd0, e_err});
        check({name, " latency"}, 32'(a_lat), 32'(e_lat));
        if (!e_err && !wr) check({name, " prdata"}, a_rd, e_rd);
        rd_out = a_rd;
    endtask

    initial begin
        logic [31:0] rd, e_rd, a_rd, addr, wd, dummy;
        logic        e_err, a_err, wr;
        logic [3:0]  st;
        int          e_lat, a_lat, sel;
        logic [31:0] ten_data [10];

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus_idle();
        wait_m  = 8'd4;
        count_m = 32'd0;

        vecs[0]  = '{1'b0, WAITA,                32'h0,         4'h0, 32'h0000_0004, 1'b0, 5};
        vecs[1]  = '{1'b1, WAITA,                32'h0,         4'h1, 32'h0,         1'b0, 5};
        vecs[2]  = '{1'b1, BASE + 32'h8,         32'h1122_3344, 4'hF, 32'h0,         1'b0, 1};
        vecs[3]  = '{1'b1, BASE + 32'h8,         32'hDEAD_BEEF, 4'h3, 32'h0,         1'b0, 1};
        vecs[4]  = '{1'b0, BASE + 32'h8,         32'h0,         4'h0, 32'h1122_BEEF, 1'b0, 1};
        vecs[5]  = '{1'b0, BASE + 32'h2_0000,    32'h0,         4'h0, 32'h0,         1'b1, 1};
        vecs[6]  = '{1'b1, CNTA,                 32'h1234_5678, 4'hF, 32'h0,         1'b1, 1};
        vecs[7]  = '{1'b0, CNTA,                 32'h0,         4'h0, 32'h0000_0007, 1'b0, 1};
        vecs[8]  = '{1'b0, BASE + 32'h8,         32'h0,         4'h0, 32'h1122_BEEF, 1'b0, 1};
        vecs[9]  = '{1'b1, BASE + 32'hFFC,       32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 1};
        vecs[10] = '{1'b1, BASE + 32'hFFC,       32'h0,         4'h0, 32'h0,         1'b0, 1};
        vecs[11] = '{1'b0, BASE + 32'hFFC,       32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 1};
        vecs[12] = '{1'b0, BASE + 32'h1000,      32'h0,         4'h0, 32'h0,         1'b1, 1};
        vecs[13] = '{1'b0, BASE - 32'h4,         32'h0,         4'h0, 32'h0,         1'b1, 1};
        vecs[14] = '{1'b0, BASE + 32'h1_0001,    32'h0,         4'h0, 32'h0,         1'b1, 1};
        vecs[15] = '{1'b1, WAITA,                32'h0000_0007, 4'hE, 32'h0,         1'b0, 1};
        vecs[16] = '{1'b0, WAITA,                32'h0,         4'h0, 32'h0000_0000, 1'b0, 1};
        vecs[17] = '{1'b1, WAITA,                32'hFFFF_FF02, 4'h1, 32'h0,         1'b0, 1};
        vecs[18] = '{1'b0, WAITA,                32'h0,         4'h0, 32'h0000_0002, 1'b0, 3};
        vecs[19] = '{1'b0, CNTA,                 32'h0,         4'h0, 32'h0000_0013, 1'b0, 3};
        vecs[20] = '{1'b1, WAITA,                32'h0,         4'h1, 32'h0,         1'b0, 3};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check_outputs_idle("reset");

        // directed table; model tracks along so later phases stay in step
        for (int i = 0; i < 21; i++) begin
            model_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].st, e_rd, e_err, e_lat);
            apb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].st, a_rd, a_err, a_lat);
            check($sformatf("vec%0d pslverr", i), {31'd0, a_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d latency", i), 32'(a_lat), 32'(vecs[i].exp_lat));
            if (!vecs[i].wr && !vecs[i].exp_err)
                check($sformatf("vec%0d prdata", i), a_rd, vecs[i].exp_rd);
        end

        // maximum wait, then abandoned write
        xfer_vs_model("wait255 set", WAITA, 1'b1, 32'h0000_00FF, 4'h1, rd);
        model_xfer(BASE + 32'h8, 1'b0, 32'h0, 4'h0, e_rd, e_err, e_lat);
        apb_xfer(BASE + 32'h8, 1'b0, 32'h0, 4'h0, a_rd, a_err, a_lat);
        check("wait255 latency", 32'(a_lat), 32'd256);
        check("wait255 prdata", a_rd, 32'h1122_BEEF);
        @(negedge clock);
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = BASE + 32'h8;
        in_pwrite = 1'b1; in_pwdata = 32'h0BAD_0BAD; in_pstrb = 4'hF;
        @(negedge clock);
        in_penable = 1'b1;
        repeat (10) @(negedge clock);
        bus_idle();
        @(negedge clock);
        model_xfer(CNTA, 1'b0, 32'h0, 4'h0, e_rd, e_err, e_lat);
        apb_xfer(CNTA, 1'b0, 32'h0, 4'h0, a_rd, a_err, a_lat);
        check("abort count", a_rd, 32'd23);
        xfer_vs_model("wait0 set", WAITA, 1'b1, 32'h0, 4'h1, rd);
        xfer_vs_model("abort data", BASE + 32'h8, 1'b0, 32'h0, 4'h0, rd);

        // ten back-to-back writes, then reset mid-ACCESS of an eleventh
        do_reset();
        check_outputs_idle("reset2");
        for (int i = 0; i < 10; i++) begin
            ten_data[i] = $urandom();
            xfer_vs_model($sformatf("b2b wr%0d", i), BASE + 32'h100 + 32'(4 * i), 1'b1,
                          ten_data[i], 4'hF, rd);
        end
        @(negedge clock);
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = BASE + 32'h100;
        in_pwrite = 1'b1; in_pwdata = ~ten_data[0]; in_pstrb = 4'hF;
        @(negedge clock);
        in_penable = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        bus_idle();
        wait_m  = 8'd4;
        count_m = 32'd0;
        check_outputs_idle("midreset");
        model_xfer(CNTA, 1'b0, 32'h0, 4'h0, e_rd, e_err, e_lat);
        apb_xfer(CNTA, 1'b0, 32'h0, 4'h0, a_rd, a_err, a_lat);
        check("midreset count", a_rd, 32'd0);
        model_xfer(WAITA, 1'b0, 32'h0, 4'h0, e_rd, e_err, e_lat);
        apb_xfer(WAITA, 1'b0, 32'h0, 4'h0, a_rd, a_err, a_lat);
        check("midreset wait", a_rd, 32'd4);
        for (int i = 0; i < 10; i++) begin
            xfer_vs_model($sformatf("b2b rd%0d", i), BASE + 32'h100 + 32'(4 * i), 1'b0,
                          32'h0, 4'h0, rd);
            check($sformatf("b2b data%0d", i), rd, ten_data[i]);
        end

        // error transfers count but leave storage alone
        do_reset();
        xfer_vs_model("err wait0", WAITA, 1'b1, 32'h0, 4'h1, rd);
        xfer_vs_model("err unmapped", BASE + 32'h2_0000, 1'b0, 32'h0, 4'h0, rd);
        xfer_vs_model("err count wr", CNTA, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        model_xfer(CNTA, 1'b0, 32'h0, 4'h0, e_rd, e_err, e_lat);
        apb_xfer(CNTA, 1'b0, 32'h0, 4'h0, a_rd, a_err, a_lat);
        check("err count value", a_rd, 32'd3);
        xfer_vs_model("err storage", BASE + 32'h8, 1'b0, 32'h0, 4'h0, rd);

        // random traffic against the model
        for (int i = 0; i < 16; i++)
            xfer_vs_model($sformatf("init%0d", i), BASE + 32'(4 * i), 1'b1, $urandom(), 4'hF, rd);
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom();
            st  = 4'($urandom_range(0, 15));
            if (sel <= 5) begin
                addr = BASE + 32'(4 * $urandom_range(0, 15));
            end else if (sel == 6) begin
                addr = WAITA;
                wd   = (wd & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
            end else if (sel == 7) begin
                addr = CNTA;
            end else if (sel == 8) begin
                addr = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 100));
            end else begin
                addr = BASE - 32'(4 * $urandom_range(1, 50));
            end
            if ($urandom_range(0, 3) == 0) @(negedge clock);
            xfer_vs_model($sformatf("rand%0d", i), addr, wr, wd, st, dummy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
